// File: rtl/pack.sv
// Shared CSR addresses, trap kinds, write masks and interrupt cause codes
// for the machine-mode CSR file.
package pack;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CSR_ADDR_W = 12;

    typedef enum logic [CSR_ADDR_W-1:0] {
        MSTATUS  = 12'h300,
        MIE      = 12'h304,
        MTVEC    = 12'h305,
        MSCRATCH = 12'h340,
        MEPC     = 12'h341,
        MCAUSE   = 12'h342,
        MTVAL    = 12'h343,
        MIP      = 12'h344,
        MCYCLE   = 12'hB00,
        MINSTRET = 12'hB02
    } destinationCSR_;

    typedef enum logic [1:0] {
        TRAP_NONE,
        TRAP_EXCEPTION,
        TRAP_INTERRUPT
    } trapType_;

    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;

    localparam logic [XLEN-1:0] MSTATUS_WMASK = 32'h0000_0088;
    // MPP is hardwired to machine mode
    localparam logic [XLEN-1:0] MSTATUS_MPP   = 32'h0000_1800;
    localparam logic [XLEN-1:0] MIE_WMASK     = 32'h0000_0888;
    localparam logic [XLEN-1:0] ALIGN_MASK    = 32'hFFFF_FFFC;

    localparam logic [XLEN-1:0] CAUSE_SOFTWARE_IRQ = 32'h8000_0003;
    localparam logic [XLEN-1:0] CAUSE_TIMER_IRQ    = 32'h8000_0007;
    localparam logic [XLEN-1:0] CAUSE_EXTERNAL_IRQ = 32'h8000_000B;

endpackage

// File: rtl/csr_counter.sv
// Loadable free-wrapping counter used for mcycle and minstret.
module csr_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count
);

    // A load takes priority over the increment in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: masked writes, trap entry / MRET sequencing,
// interrupt pending logic and the cycle / instret counters.
module csr_file
    import pack::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MEPC_RESET  = 32'h0000_0000
) (
    input  logic           clock,
    input  logic           resetN,
    input  destinationCSR_ readCSR,
    output logic [31:0]    readData,
    input  logic           writeEnable,
    input  destinationCSR_ writeCSR,
    input  logic [31:0]    writeData,
    input  logic           retire,
    input  logic           trapValid,
    input  logic [31:0]    trapCause,
    input  logic [31:0]    trapPC,
    input  logic [31:0]    trapValue,
    input  logic           mretCommit,
    input  logic           externalIrq,
    input  logic           timerIrq,
    input  logic           softwareIrq,
    output logic [31:0]    trapVector,
    output logic [31:0]    mepcOut,
    output logic           interruptRequest
);

    logic            status_mie;
    logic            status_mpie;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mip_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic [XLEN-1:0] mcycle_q;
    logic [XLEN-1:0] minstret_q;
    logic            irq_q;
    logic [XLEN-1:0] mstatus_value;

    logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch;
    logic wr_mepc, wr_mcause, wr_mtval, wr_mcycle, wr_minstret;

    always_comb begin
        wr_mstatus  = writeEnable && (writeCSR == MSTATUS);
        wr_mie      = writeEnable && (writeCSR == MIE);
        wr_mtvec    = writeEnable && (writeCSR == MTVEC);
        wr_mscratch = writeEnable && (writeCSR == MSCRATCH);
        wr_mepc     = writeEnable && (writeCSR == MEPC);
        wr_mcause   = writeEnable && (writeCSR == MCAUSE);
        wr_mtval    = writeEnable && (writeCSR == MTVAL);
        wr_mcycle   = writeEnable && (writeCSR == MCYCLE);
        wr_minstret = writeEnable && (writeCSR == MINSTRET);
    end

    always_comb begin
        mstatus_value           = MSTATUS_MPP;
        mstatus_value[MIE_BIT]  = status_mie;
        mstatus_value[MPIE_BIT] = status_mpie;
    end

    // Per CSR: trap entry beats MRET beats a software write
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            mie_q       <= '0;
            mip_q       <= '0;
            mtvec_q     <= MTVEC_RESET;
            mepc_q      <= MEPC_RESET;
            mscratch_q  <= '0;
            mcause_q    <= '0;
            mtval_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            mip_q <= {20'd0, externalIrq, 3'd0, timerIrq, 3'd0, softwareIrq, 3'd0};
            irq_q <= status_mie & (|(mip_q & mie_q));

            if (wr_mie)      mie_q      <= writeData & MIE_WMASK;
            if (wr_mtvec)    mtvec_q    <= writeData & ALIGN_MASK;
            if (wr_mscratch) mscratch_q <= writeData;

            if (trapValid) begin
                mepc_q      <= trapPC & ALIGN_MASK;
                mcause_q    <= trapCause;
                mtval_q     <= trapValue;
                status_mpie <= status_mie;
                status_mie  <= 1'b0;
            end else begin
                if (wr_mepc)   mepc_q   <= writeData & ALIGN_MASK;
                if (wr_mcause) mcause_q <= writeData;
                if (wr_mtval)  mtval_q  <= writeData;
                if (mretCommit) begin
                    status_mie  <= status_mpie;
                    status_mpie <= 1'b1;
                end else if (wr_mstatus) begin
                    status_mie  <= writeData[MIE_BIT];
                    status_mpie <= writeData[MPIE_BIT];
                end
            end
        end
    end

    csr_counter #(.WIDTH(XLEN)) u_mcycle (
        .clk        (clock),
        .rst_n      (resetN),
        .inc        (1'b1),
        .load       (wr_mcycle),
        .load_value (writeData),
        .count      (mcycle_q)
    );

    csr_counter #(.WIDTH(XLEN)) u_minstret (
        .clk        (clock),
        .rst_n      (resetN),
        .inc        (retire),
        .load       (wr_minstret),
        .load_value (writeData),
        .count      (minstret_q)
    );

    // Read port shows committed state; same-cycle writes are forwarded upstream
    always_comb begin
        readData = '0;
        case (readCSR)
            MSTATUS:  readData = mstatus_value;
            MIE:      readData = mie_q;
            MTVEC:    readData = mtvec_q;
            MSCRATCH: readData = mscratch_q;
            MEPC:     readData = mepc_q;
            MCAUSE:   readData = mcause_q;
            MTVAL:    readData = mtval_q;
            MIP:      readData = mip_q;
            MCYCLE:   readData = mcycle_q;
            MINSTRET: readData = minstret_q;
            default:  readData = '0;
        endcase
    end

    assign trapVector       = mtvec_q;
    assign mepcOut          = mepc_q;
    assign interruptRequest = irq_q;

endmodule
